// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative one-bit-per-cycle HI/LO multiply/divide unit with MTHI/MTLO writes
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;
   state_t state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, prod_fix;
   logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, abs_a, abs_b, q_fix, r_fix;
   logic [CW-1:0] cnt_q, cnt_d;
   logic div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, done_q, done_d;
   logic sgn, sa, sb;
   logic [WIDTH:0] sum, trial, diff;
   always_comb begin
      sgn = ~op[0];
      sa = sgn & A[WIDTH-1];
      sb = sgn & B[WIDTH-1];
      abs_a = sa ? -A : A;
      abs_b = sb ? -B : B;
      sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & m_q};
      trial = acc_q[2*WIDTH-1:WIDTH-1];
      diff = trial - {1'b0, m_q};
      prod_fix = neg_lo_q ? -acc_q : acc_q;
      q_fix = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      r_fix = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      state_d = state_q;
      acc_d = acc_q;
      m_d = m_q;
      cnt_d = cnt_q;
      div_d = div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      done_d = 1'b0;
      hi_d = (state_q == IDLE && hi_we) ? wdata : hi_q;
      lo_d = (state_q == IDLE && lo_we) ? wdata : lo_q;
      if (state_q == IDLE && start) begin
         div_d = op[1];
         neg_lo_d = sa ^ sb;
         neg_hi_d = sa;
         m_d = op[1] ? abs_b : abs_a;
         acc_d = {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
         cnt_d = CW'(WIDTH - 1);
         state_d = RUN;
         if (op[1] && B == '0) begin
            acc_d = {A, {WIDTH{1'b1}}};
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
            state_d = FIXUP;
         end
      end else if (state_q == RUN) begin
         acc_d = div_q ? {diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0], acc_q[WIDTH-2:0], ~diff[WIDTH]}
                       : {sum, acc_q[WIDTH-1:1]};
         cnt_d = cnt_q - 1'b1;
         state_d = (cnt_q == '0) ? FIXUP : RUN;
      end else if (state_q == FIXUP) begin
         hi_d = div_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
         lo_d = div_q ? q_fix : prod_fix[WIDTH-1:0];
         done_d = 1'b1;
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q <= '0;
         m_q <= '0;
         cnt_q <= '0;
         div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         done_q <= 1'b0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         m_q <= m_d;
         cnt_q <= cnt_d;
         div_q <= div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         done_q <= done_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end
   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign hi = hi_q;
   assign lo = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven and randomized checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
   logic clk = 1'b0, rst, start, hi_we, lo_we, busy, done;
   logic [1:0] op;
   logic [31:0] A, B, wdata, hi, lo;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );
   typedef struct {
      logic [1:0] op;
      logic [31:0] a, b, hi, lo;
      int lat;
   } vec_t;
   vec_t vt[8];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask
   function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint p, q, r;
      logic [63:0] u;
      case (o)
         2'd0: begin p = longint'($signed(a)) * longint'($signed(b)); eh = p[63:32]; el = p[31:0]; end
         2'd1: begin u = {32'd0, a} * {32'd0, b}; eh = u[63:32]; el = u[31:0]; end
         default: begin
            if (b == 0) begin
               eh = a;
               el = 32'hFFFF_FFFF;
            end else begin
               q = (o == 2'd2) ? longint'($signed(a)) / longint'($signed(b)) : longint'(a) / longint'(b);
               r = (o == 2'd2) ? longint'($signed(a)) % longint'($signed(b)) : longint'(a) % longint'(b);
               eh = r[31:0];
               el = q[31:0];
            end
         end
      endcase
   endfunction
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0; op = $urandom; A = $urandom; B = $urandom;
   endtask
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask
   task automatic run(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el, input int lat);
      int n;
      launch(o, a, b);
      chk({name, " busy"}, 32'(busy), 32'd1);
      wait_done(n);
      chk({name, " latency"}, 32'(n), 32'(lat));
      chk({name, " hi"}, hi, eh);
      chk({name, " lo"}, lo, el);
      chk({name, " idle"}, 32'(busy), 32'd0);
   endtask
   initial begin
      int n;
      logic [31:0] eh, el, a, b;
      logic [1:0] o;
      vt[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
      vt[1] = '{2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
      vt[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33};
      vt[3] = '{2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
      vt[4] = '{2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 33};
      vt[5] = '{2'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1};
      vt[6] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33};
      vt[7] = '{2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
      rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = '0; A = '0; B = '0; wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      for (int i = 0; i < 8; i++) run($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].lat);
      // done must be a single-cycle pulse
      @(posedge clk); #1;
      chk("done pulse width", 32'(done), 32'd0);
      // ignored start and MTHI while a MULT is running
      launch(2'd0, 32'hFFFF_FFFD, 32'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1; op = 2'd3; A = 32'd100; B = 32'd3; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      wait_done(n);
      chk("busy-ignore latency", 32'(n + 5), 32'd33);
      chk("busy-ignore hi", hi, 32'hFFFF_FFFF);
      chk("busy-ignore lo", lo, 32'hFFFF_FFEB);
      @(posedge clk); #1;
      chk("busy-ignore no second op", 32'(busy), 32'd0);
      // reset in the middle of a DIV
      launch(2'd2, 32'd1000, 32'd7);
      repeat (8) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst hi", hi, 32'd0);
      chk("midrst lo", lo, 32'd0);
      @(negedge clk) rst = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) n++;
      end
      chk("midrst no done", 32'(n), 32'd0);
      // MTLO / MTHI while idle, and a write in the start cycle being overwritten
      @(negedge clk); hi_we = 1'b1; wdata = 32'h55AA_0000;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_1234;
      @(posedge clk); #1;
      lo_we = 1'b0;
      chk("mtlo lo", lo, 32'h0000_1234);
      chk("mtlo hi", hi, 32'h55AA_0000);
      @(negedge clk);
      start = 1'b1; op = 2'd3; A = 32'd50; B = 32'd7; lo_we = 1'b1; wdata = 32'hCAFE_0001;
      @(posedge clk); #1;
      start = 1'b0; lo_we = 1'b0;
      chk("start-cycle mtlo", lo, 32'hCAFE_0001);
      wait_done(n);
      chk("start-cycle overwrite lo", lo, 32'd7);
      chk("start-cycle overwrite hi", hi, 32'd1);
      // random operations against the arithmetic model, back to back
      for (int i = 0; i < 60; i++) begin
         o = 2'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = $urandom_range(1, 15);
            default: ;
         endcase
         model(o, a, b, eh, el);
         run($sformatf("rand%0d op%0d", i, o), o, a, b, eh, el, (o[1] && b == 0) ? 1 : 33);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
